stream_fn: RTL

//  Nios II multi-cycle custom instruction that runs a DMA-fed reduction over a memory array.
//  On start it programs the DMA controller over its control port, then receives the array

---
 rtl/stream_fn.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/stream_fn.sv
// Multi-cycle custom instruction: programs a DMA, buffers the streamed array in a FIFO and
// reduces it to a saturating unsigned sum or an unsigned max.
module stream_fn #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] WM_BASE    = 32'h0
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              clk_en,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    input  logic              n,
    output logic [31:0]       result,
    output logic              done,
    output logic [2:0]        dma_ctl_address,
    output logic              dma_ctl_chipselect,
    output logic              dma_ctl_write_n,
    output logic [31:0]       dma_ctl_writedata,
    input  logic [31:0]       dma_ctl_readdata,
    input  logic [4:0]        dma_wm_address,
    input  logic              dma_wm_chipselect,
    input  logic              dma_wm_write_n,
    input  logic [DATA_W-1:0] dma_wm_writedata,
    output logic              dma_wm_waitrequest
);

    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] DepthW = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] ByteScale = 32'(DATA_W / 8);
    localparam logic [31:0] SizeBits  = (DATA_W == 8)  ? 32'h1 :
                                        (DATA_W == 16) ? 32'h2 : 32'h4;
    // GO | LEEN | WCON | size
    localparam logic [31:0] CtlWord   = 32'h0000_0288 | SizeBits;

    typedef enum logic [2:0] {
        StIdle, StClr, StRaddr, StWaddr, StLen, StCtl, StStream, StFin
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  consumed_q, consumed_d;
    logic [CNT_W-1:0]  pushed_q, pushed_d;
    logic              mode_q, mode_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       result_q, result_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [2:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     fill_q, fill_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic        full, empty, push, store, pop;
    logic [31:0] head;
    logic [32:0] sum_ext;
    logic        unused_inputs;

    assign unused_inputs = ^{dma_ctl_readdata, dma_wm_address, datab};

    assign full    = (fill_q == DepthW);
    assign empty   = (fill_q == '0);
    assign head    = 32'(mem_q[rd_ptr_q]);
    assign sum_ext = {1'b0, acc_q} + {1'b0, head};

    // Accepted bus writes are only stored while streaming and below the requested count.
    assign push  = dma_wm_chipselect & ~dma_wm_write_n & ~full;
    assign store = push && (state_q == StStream) && (pushed_q != count_q);
    assign pop   = clk_en && (state_q == StStream) && !empty;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        consumed_d = consumed_q;
        pushed_d   = pushed_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        result_d   = result_q;
        done_d     = 1'b0;
        cs_d       = cs_q;
        wn_d       = wn_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (clk_en) begin
            cs_d    = 1'b0;
            wn_d    = 1'b1;
            addr_d  = 3'd0;
            wdata_d = 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_d     = dataa;
                        count_d    = datab[CNT_W-1:0];
                        mode_d     = n;
                        acc_d      = 32'd0;
                        consumed_d = '0;
                        pushed_d   = '0;
                        if (datab[CNT_W-1:0] == '0) begin
                            state_d = StFin;
                        end else begin
                            state_d = StClr;
                            cs_d    = 1'b1;
                            wn_d    = 1'b0;
                        end
                    end
                end
                StClr: begin
                    state_d = StRaddr;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 3'd1;
                    wdata_d = base_q;
                end
                StRaddr: begin
                    state_d = StWaddr;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 3'd2;
                    wdata_d = WM_BASE;
                end
                StWaddr: begin
                    state_d = StLen;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 3'd3;
                    wdata_d = 32'(count_q) * ByteScale;
                end
                StLen: begin
                    state_d = StCtl;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 3'd6;
                    wdata_d = CtlWord;
                end
                StCtl: state_d = StStream;
                StStream: begin
                    if (pop) begin
                        if (mode_q) begin
                            acc_d = (head > acc_q) ? head : acc_q;
                        end else begin
                            acc_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
                        end
                        consumed_d = consumed_q + 1'b1;
                        if (consumed_d == count_q) begin
                            state_d = StFin;
                        end
                    end
                end
                StFin: begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (store) begin
            pushed_d = pushed_q + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (store && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!store && pop) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= StIdle;
            base_q     <= 32'd0;
            count_q    <= '0;
            consumed_q <= '0;
            pushed_q   <= '0;
            mode_q     <= 1'b0;
            acc_q      <= 32'd0;
            result_q   <= 32'd0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            wn_q       <= 1'b1;
            addr_q     <= 3'd0;
            wdata_q    <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            consumed_q <= consumed_d;
            pushed_q   <= pushed_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            wn_q       <= wn_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            mem_q[wr_ptr_q] <= dma_wm_writedata;
        end
    end

    assign result             = result_q;
    assign done               = done_q;
    assign dma_ctl_address    = addr_q;
    assign dma_ctl_chipselect = cs_q;
    assign dma_ctl_write_n    = wn_q;
    assign dma_ctl_writedata  = wdata_q;
    assign dma_wm_waitrequest = full;

endmodule
